serial_subtractor: RTL and testbench

// - Bit-serial two's-complement subtractor: DIFF = A - B, processed LSB first, one bit per clock.
// - Inverse counterpart of the combinational ripple adder.
// - Reuses one full-subtractor cell over WIDTH cycles instead of WIDTH cells.
// - Sits behind the ui_in operand bus with a start/done handshake; results drive uo_out.

---
 rtl/serial_subtractor.sv | 92 +++++++++
 tb/tb_serial_subtractor.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (A - B), LSB first, one full-subtractor cell reused over WIDTH cycles.
// Handshake: start accepted only in IDLE; done pulses one cycle with diff/bout/zero valid; results held until next completion.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, dsr_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q, zero_q;

  logic             d_bit, br_d;
  logic [WIDTH-1:0] dsr_d;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    d_bit = a_q[0] ^ b_q[0] ^ br_q;
    br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    dsr_d = {d_bit, dsr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dsr_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            dsr_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          dsr_q <= dsr_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            // Final bit: publish the complete result alongside the DONE transition.
            diff_q  <= dsr_d;
            bout_q  <= br_d;
            zero_q  <= (dsr_d == '0);
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=4) with hand-computed results.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] a, b;
  logic       busy, done, bout, zero;
  logic [3:0] diff;

  int n_vec = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .zero (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept one operation, then wait (bounded) for done and check result and latency.
  task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic [3:0] ed, input logic eb, input logic ez);
    int n;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, n, 4);
    chk({tag, ".diff"}, diff, ed);
    chk({tag, ".bout"}, bout, eb);
    chk({tag, ".zero"}, zero, ez);
    @(negedge clk);
    chk({tag, ".pulse"}, done, 0);
    chk({tag, ".hold"}, diff, ed);
  endtask

  initial begin
    int pulses, last, first;
    logic [3:0] cap;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.diff", diff, 0);
    chk("rst.bout", bout, 0);
    chk("rst.zero", zero, 0);

    run_op("9-3",  4'd9,  4'd3,  4'd6,  1'b0, 1'b0);
    run_op("3-9",  4'd3,  4'd9,  4'hA,  1'b1, 1'b0);
    run_op("5-5",  4'd5,  4'd5,  4'd0,  1'b0, 1'b1);
    run_op("0-15", 4'd0,  4'd15, 4'd1,  1'b1, 1'b0);
    run_op("15-0", 4'd15, 4'd0,  4'd15, 1'b0, 1'b0);

    // Second start while shifting must be ignored.
    @(negedge clk);
    a = 4'd12; b = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; cap = '0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin pulses++; cap = diff; end
      @(negedge clk);
    end
    chk("ign.pulses", pulses, 1);
    chk("ign.diff", cap, 7);

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    a = 4'd7; b = 4'd2; start = 1'b1;
    pulses = 0; last = -1; first = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        chk("held.diff", diff, 5);
        if (last >= 0) chk("held.period", i - last, 6);
        else first = i;
        last = i;
      end
    end
    start = 1'b0;
    chk("held.pulses", pulses, 3);
    chk("held.first", first, 4);
    repeat (10) @(negedge clk);

    // Reset while cnt=2 aborts without a done pulse.
    a = 4'd9; b = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.diff", diff, 0);
    chk("abort.bout", bout, 0);
    chk("abort.zero", zero, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("abort.pulses", pulses, 0);

    run_op("post", 4'd3, 4'd9, 4'hA, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
